// File: rtl/burst_arbiter.sv
// Two-port (icache/dcache) line arbiter onto a 64-bit burst memory bus.
// Owns one 4-beat line buffer. Keeps saturating grant and conflict counters.
module burst_arbiter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dfp_read,
  input  logic [31:0]          dfp_addr,
  output logic [255:0]         dfp_rdata,
  output logic                 dfp_resp,
  input  logic                 dfp_dread,
  input  logic                 dfp_dwrite,
  input  logic [31:0]          dfp_daddr,
  input  logic [255:0]         dfp_dwdata,
  output logic [255:0]         dfp_drdata,
  output logic                 dfp_dresp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [63:0]          bmem_wdata,
  input  logic                 bmem_ready,
  input  logic                 bmem_rvalid,
  input  logic [63:0]          bmem_rdata,
  output logic [CNT_WIDTH-1:0] i_req_count,
  output logic [CNT_WIDTH-1:0] d_req_count,
  output logic [CNT_WIDTH-1:0] conflict_count
);
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR, RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;       // 1 = dcache owns the bus
  logic                  last_d_q, last_d_d;     // 1 = dcache won the last conflict
  logic [31:0]           addr_q, addr_d;
  logic [3:0][63:0]      line_q, line_d;
  logic [1:0]            idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  icnt_q, icnt_d, dcnt_q, dcnt_d, ccnt_q, ccnt_d;

  logic i_req, d_req, conflict, pick_d;

  assign i_req    = dfp_read;
  assign d_req    = dfp_dread | dfp_dwrite;
  assign conflict = i_req & d_req;
  // dcache wins by default; icache wins a conflict right after dcache won one
  assign pick_d   = d_req & ~(conflict & last_d_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    line_d   = line_q;
    idx_d    = idx_q;
    icnt_d   = icnt_q;
    dcnt_d   = dcnt_q;
    ccnt_d   = ccnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          owner_d = pick_d;
          addr_d  = pick_d ? {dfp_daddr[31:5], 5'b0} : {dfp_addr[31:5], 5'b0};
          idx_d   = 2'd0;
          if (pick_d && dfp_dwrite) begin
            line_d  = dfp_dwdata;
            state_d = WR;
          end else begin
            state_d = RD_CMD;
          end
          if (pick_d) begin
            if (dcnt_q != '1) dcnt_d = dcnt_q + CNT_ONE;
          end else begin
            if (icnt_q != '1) icnt_d = icnt_q + CNT_ONE;
          end
          if (conflict) begin
            last_d_d = pick_d;
            if (ccnt_q != '1) ccnt_d = ccnt_q + CNT_ONE;
          end
        end
      end
      RD_CMD: if (bmem_ready) state_d = RD_DATA;
      RD_DATA: begin
        if (bmem_rvalid) begin
          line_d[idx_q] = bmem_rdata;
          idx_d         = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = RESP;
        end
      end
      WR: begin
        if (bmem_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      line_q   <= '0;
      idx_q    <= '0;
      icnt_q   <= '0;
      dcnt_q   <= '0;
      ccnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      idx_q    <= idx_d;
      icnt_q   <= icnt_d;
      dcnt_q   <= dcnt_d;
      ccnt_q   <= ccnt_d;
    end
  end

  assign bmem_addr      = addr_q;
  assign bmem_read      = (state_q == RD_CMD);
  assign bmem_write     = (state_q == WR);
  assign bmem_wdata     = (state_q == WR) ? line_q[idx_q] : 64'h0;
  assign dfp_rdata      = line_q;
  assign dfp_drdata     = line_q;
  assign dfp_resp       = (state_q == RESP) & ~owner_q;
  assign dfp_dresp      = (state_q == RESP) &  owner_q;
  assign i_req_count    = icnt_q;
  assign d_req_count    = dcnt_q;
  assign conflict_count = ccnt_q;
endmodule

// File: tb/tb_burst_arbiter.sv
// Bench for burst_arbiter: behavioural burst memory plus per-port scoreboards.
module tb_burst_arbiter;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dfp_read = 1'b0, dfp_dread = 1'b0, dfp_dwrite = 1'b0;
  logic [31:0]   dfp_addr = '0, dfp_daddr = '0;
  logic [255:0]  dfp_dwdata = '0;
  logic [255:0]  dfp_rdata, dfp_drdata;
  logic          dfp_resp, dfp_dresp;
  logic [31:0]   bmem_addr;
  logic          bmem_read, bmem_write;
  logic [63:0]   bmem_wdata;
  logic          bmem_ready = 1'b1, bmem_rvalid = 1'b0;
  logic [63:0]   bmem_rdata = '0;
  logic [CW-1:0] i_req_count, d_req_count, conflict_count;

  burst_arbiter #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .dfp_read(dfp_read), .dfp_addr(dfp_addr), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .dfp_dread(dfp_dread), .dfp_dwrite(dfp_dwrite), .dfp_daddr(dfp_daddr),
    .dfp_dwdata(dfp_dwdata), .dfp_drdata(dfp_drdata), .dfp_dresp(dfp_dresp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rvalid(bmem_rvalid),
    .bmem_rdata(bmem_rdata), .i_req_count(i_req_count), .d_req_count(d_req_count),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // memory model controls (written by main only)
  bit stall_alt = 1'b0;
  bit addr_mix  = 1'b1;
  int burst_len = 4;

  function automatic logic [63:0] beat(input logic [31:0] a, input int k);
    logic [7:0] b;
    b = 8'((k + 1) * 17);
    return {8{b}} ^ (addr_mix ? {a, a} : 64'h0);
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[64*k +: 64] = beat({a[31:5], 5'b0}, k);
    return r;
  endfunction

  // memory model / monitor state (written by memory process only)
  logic [63:0] wr_log[$];
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [63:0] stall_wd = '0;
  bit stall_pend = 0, rd_act = 0;
  int bk = 0, rd_cyc = 0, stall_cnt = 0, stall_bad = 0, i_pulses = 0, d_pulses = 0;

  always begin
    @(negedge clk);
    if (bmem_write && bmem_ready) begin
      wr_log.push_back(bmem_wdata);
      last_wr_addr = bmem_addr;
    end
    if (stall_pend && bmem_write && bmem_wdata !== stall_wd) stall_bad++;
    if (bmem_write && !bmem_ready) stall_cnt++;
    stall_pend = bmem_write && !bmem_ready;
    stall_wd   = bmem_wdata;
    if (bmem_read) rd_cyc++;
    if (dfp_resp)  i_pulses++;
    if (dfp_dresp) d_pulses++;
    if (bmem_rvalid) bk++;
    if (bmem_read && bmem_ready) begin
      bk = 0; rd_act = 1; last_rd_addr = bmem_addr;
    end
    @(posedge clk); #1;
    if (rd_act && bk < burst_len) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = beat(last_rd_addr, bk);
    end else begin
      bmem_rvalid = 1'b0;
      rd_act      = 0;
    end
    bmem_ready = stall_alt ? ~bmem_ready : 1'b1;
  end

  // scoreboards, filled as requests are driven
  logic [255:0] iq[$], dq[$];
  logic [63:0]  ewq[$];
  int           order[$];
  int           wr_ptr = 0;
  logic [255:0] last_i_rdata;

  task automatic run(input bit ir, input bit dr, input bit dw, input logic [31:0] ia,
                     input logic [31:0] da, input logic [255:0] wd, output int lat_i);
    bit pend_i, pend_d;
    lat_i = -1;
    order.delete();
    dfp_read = ir; dfp_addr = ia; dfp_dread = dr; dfp_dwrite = dw;
    dfp_daddr = da; dfp_dwdata = wd;
    if (ir) iq.push_back(exp_line(ia));
    if (dr && !dw) dq.push_back(exp_line(da));
    if (dw) for (int k = 0; k < 4; k++) ewq.push_back(wd[64*k +: 64]);
    pend_i = ir; pend_d = dr | dw;
    for (int c = 0; c < 200 && (pend_i || pend_d); c++) begin
      @(negedge clk);
      if (dfp_resp) begin
        chk("i_resp_expected", 1'b1, pend_i);
        if (pend_i && iq.size() > 0) chk("i_rdata", dfp_rdata, iq.pop_front());
        last_i_rdata = dfp_rdata;
        lat_i = c; pend_i = 0; dfp_read = 1'b0; order.push_back(0);
      end
      if (dfp_dresp) begin
        chk("d_resp_expected", 1'b1, pend_d);
        if (pend_d && dfp_dwrite) begin
          for (int k = 0; k < 4; k++) begin
            if (wr_ptr < wr_log.size() && ewq.size() > 0) begin
              chk("wr_beat", wr_log[wr_ptr], ewq.pop_front());
              wr_ptr++;
            end else chk("wr_beat_missing", 1'b0, 1'b1);
          end
        end else if (pend_d && dq.size() > 0) chk("d_rdata", dfp_drdata, dq.pop_front());
        pend_d = 0; dfp_dread = 1'b0; dfp_dwrite = 1'b0; order.push_back(1);
      end
      @(posedge clk); #1;
    end
    if (pend_i || pend_d) chk("resp_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int lat, rd0, ip0, dp0, sc0;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_bmem_read", bmem_read, 1'b0);
    chk("rst_bmem_write", bmem_write, 1'b0);
    chk("rst_resp", {dfp_resp, dfp_dresp}, 2'b00);
    chk("rst_addr", bmem_addr, 32'h0);
    chk("rst_wdata", bmem_wdata, 64'h0);
    chk("rst_rdata", dfp_rdata, 256'h0);
    chk("rst_drdata", dfp_drdata, 256'h0);
    chk("rst_counts", {i_req_count, d_req_count, conflict_count}, 12'h0);
    @(posedge clk); #1;

    // icache read, spec beat pattern, immediate memory
    addr_mix = 1'b0;
    rd0 = rd_cyc;
    run(1, 0, 0, 32'h0000_1234, 32'h0, 256'h0, lat);
    chk("rd_addr", last_rd_addr, 32'h0000_1220);
    chk("rd_cmd_cycles", rd_cyc - rd0, 1);
    chk("rd_latency", lat, 6);
    chk("rd_beat0", last_i_rdata[63:0], 64'h1111_1111_1111_1111);
    chk("rd_beat3", last_i_rdata[255:192], 64'h4444_4444_4444_4444);
    chk("i_cnt_1", i_req_count, 4'd1);
    addr_mix = 1'b1;

    // dcache write with alternating ready stalls
    stall_alt = 1'b1;
    ip0 = i_pulses; dp0 = d_pulses; sc0 = stall_cnt;
    run(0, 0, 1, 32'h0, 32'h8000_0040,
        {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
         64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001}, lat);
    stall_alt = 1'b0;
    chk("wr_addr", last_wr_addr, 32'h8000_0040);
    chk("wr_stalled", stall_cnt > sc0, 1'b1);
    chk("wr_hold", stall_bad, 0);
    chk("wr_dresp_pulses", d_pulses - dp0, 1);
    chk("wr_no_iresp", i_pulses - ip0, 0);
    chk("d_cnt_1", d_req_count, 4'd1);

    // two back-to-back conflicts alternate priority
    run(1, 1, 0, 32'h0000_2000, 32'h0000_3008, 256'h0, lat);
    chk("conf1_first_d", order.size() > 0 ? order[0] : -1, 1);
    chk("conf_cnt_1", conflict_count, 4'd1);
    run(1, 1, 0, 32'h0000_4010, 32'h0000_5000, 256'h0, lat);
    chk("conf2_first_i", order.size() > 0 ? order[0] : -1, 0);
    chk("conf_cnt_2", conflict_count, 4'd2);

    // dread + dwrite together: write wins, no read command
    rd0 = rd_cyc; dp0 = d_pulses;
    run(0, 1, 1, 32'h0, 32'h0000_6020, {4{64'h0123_4567_89AB_CDEF}}, lat);
    chk("rw_no_read", rd_cyc - rd0, 0);
    chk("rw_dresp", d_pulses - dp0, 1);

    // reset in RD_DATA after beat 1, stray beats follow
    burst_len = 6;
    ip0 = i_pulses; dp0 = d_pulses;
    dfp_read = 1'b1; dfp_addr = 32'h0000_7000;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; dfp_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 burst_len = 4;
    @(negedge clk);
    chk("abort_no_resp", (i_pulses - ip0) + (d_pulses - dp0), 0);
    chk("abort_idle", {bmem_read, bmem_write}, 2'b00);
    chk("abort_counts", {i_req_count, d_req_count, conflict_count}, 12'h0);
    @(posedge clk); #1;
    run(1, 0, 0, 32'h0000_7040, 32'h0, 256'h0, lat);
    chk("post_abort_cnt", i_req_count, 4'd1);
    chk("post_abort_lat", lat, 6);

    // saturation
    do_reset();
    for (int n = 0; n < 14; n++) run(1, 0, 0, 32'h0000_0100 + 32'(n * 32), 32'h0, 256'h0, lat);
    chk("sat_pre", i_req_count, 4'hE);
    for (int n = 0; n < 3; n++) run(1, 0, 0, 32'h0000_0900 + 32'(n * 32), 32'h0, 256'h0, lat);
    chk("sat_hold", i_req_count, 4'hF);
    chk("sat_d_zero", d_req_count, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
